fetch_decode_buffer: RTL and testbench
======================================

# fetch_decode_buffer

Consumer end of the fetch→decode hand-off. It accepts fetch packets (pc, raw instruction) under a valid/ready handshake, holds up to DEPTH of them in a FIFO, and presents them in order to the decode stage under its own valid/ready handshake. It absorbs decode stalls without a combinational ready path back to fetch, flags misaligned fetch PCs, and discards all held packets on a pipeline flush.

## Interface
- DEPTH, 2: number of packet entries; power of two, ≥2.
- clk  in  1  single clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- in_valid  in  1  fetch presents a packet.
- in_ready  out  1  buffer can accept a packet this cycle.
- in_pc  in  64  pc of the fetched instruction.
- in_instr  in  32  raw instruction word.
- flush  in  1  discard all contents, for example on a redirect.
- out_valid  out  1  head packet is valid for decode.
- out_ready  in  1  decode consumes the head packet this cycle.
- out_pc  out  64  head packet pc.
- out_instr  out  32  head packet raw instruction.
- out_misalign  out  1  head packet pc[1:0] != 0.
- count  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Storage: DEPTH entries, each 97 bits (pc, instr, misalign). Head and tail pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. count runs from 0 to DEPTH.
- Push occurs when in_valid && in_ready && !flush. The packet is written at tail, tail increments, and misalign is computed from in_pc[1:0] at write time.
- Pop occurs when out_valid && out_ready && !flush. Head increments.
- Push and pop in the same cycle: both happen and count is unchanged.
- in_ready = (count != DEPTH). It depends only on registered state; there is no path from out_ready to in_ready. When full, a push is refused even if a pop happens that cycle.
- out_valid = (count != 0). out_pc, out_instr and out_misalign are driven from the head entry. When empty they hold the last head-entry contents, which are don't-care and must not be checked.
- There is no bypass: a packet written into an empty buffer appears on the outputs the next cycle.
- flush has priority over everything. At the edge it sets count to 0 and head and tail to 0. A push or pop requested in the same cycle is ignored. The next cycle shows out_valid=0 and in_ready=1.
- Entry data registers need not be reset. Only the pointers and count are reset.
- A misaligned packet is passed through unchanged with out_misalign=1. The buffer raises no exception itself.

## Timing
- Reset (async assert, resetn=0): count=0, head=0, tail=0. Therefore out_valid=0, in_ready=1 and out_misalign=0.
- Release of resetn is synchronous to clk. The first push is possible on the first rising edge after release.
- Latency from in_valid&&in_ready at edge N to out_valid at edge N+1 is 1 cycle.
- Throughput is 1 packet/cycle sustained when out_ready=1 every cycle and count stays ≥1.
- Full and stalled (out_ready=0): in_ready=0 and the head outputs stay stable every cycle.
- Wrap: after DEPTH pushes the tail returns to 0. Order is preserved across the wrap.
- Asserting resetn=0 mid-operation immediately drops out_valid and raises in_ready. Contents are lost.
- Fetch-side rule: fetch must hold in_pc and in_instr stable while in_valid && !in_ready.
- Decode-side rule: decode may change out_ready freely.

## Test plan
- Reset values:
  - Stimulus: assert resetn=0 mid-cycle with count=2.
  - Required response: out_valid=0, in_ready=1 and count=0 immediately, without waiting for clk.
- Single pass:
  - Stimulus: push pc=0x8000_0000, instr=0x0000_0013 with out_ready=1.
  - Required response: next cycle out_valid=1 with the same pc and instr and out_misalign=0. The cycle after, out_valid=0.
- Back-pressure:
  - Stimulus: hold out_ready=0 and push pc 0x1000, 0x1004, 0x1008.
  - Required response: the first two are accepted (count=2) and in_ready=0 on the third. Raise out_ready: outputs show 0x1000 then 0x1004, then 0x1008 is accepted.
- Streaming with wrap:
  - Stimulus: 10 consecutive pushes pc=0x2000+4k with out_ready=1.
  - Required response: 10 pops in order at 1/cycle, count stays ≤1, and tail wraps correctly.
- Flush collision:
  - Stimulus: at count=2, assert flush together with in_valid (pc 0x3000) and out_ready.
  - Required response: next cycle count=0, out_valid=0 and in_ready=1. 0x3000 never appears.
- Misalign:
  - Stimulus: push pc=0x4002.
  - Required response: out_misalign=1 and out_pc=0x4002. The following push of pc=0x4004 shows out_misalign=0.

Source files
------------

// File: rtl/fetch_decode_buffer.sv
// fetch_decode_buffer: in-order FIFO between fetch and decode with flush and misalign flag.
// in_ready depends only on registered occupancy, so decode stalls never reach fetch combinationally.
module fetch_decode_buffer #(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [63:0]              in_pc,
    input  logic [31:0]              in_instr,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [63:0]              out_pc,
    output logic [31:0]              out_instr,
    output logic                     out_misalign,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
    logic [63:0]   pc_q    [DEPTH];
    logic [31:0]   instr_q [DEPTH];
    logic          mis_q   [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic          push;
    logic          pop;
    assign in_ready  = count != FULL;
    assign out_valid = count != '0;
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;
    assign out_pc    = pc_q[head];
    assign out_instr = instr_q[head];
    // Gated so the flag reads 0 out of reset, when the unreset entry bits are unknown.
    assign out_misalign = out_valid && mis_q[head];
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= pop ? head + AW'(1) : head;
            tail  <= push ? tail + AW'(1) : tail;
            count <= count + (AW + 1)'(push) - (AW + 1)'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push) begin
            pc_q[tail]    <= in_pc;
            instr_q[tail] <= in_instr;
            mis_q[tail]   <= in_pc[1:0] != 2'b00;
        end
    end
endmodule

// File: tb/tb_fetch_decode_buffer.sv
// tb_fetch_decode_buffer: directed checks of reset, handshake, back-pressure, wrap, flush and misalign.
module tb_fetch_decode_buffer;
    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_pc;
    logic [31:0] in_instr;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        out_misalign;
    logic [1:0]  count;
    int          n_assert = 0;
    int          n_fail   = 0;

    fetch_decode_buffer #(.DEPTH(2)) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
        .out_misalign(out_misalign), .count(count)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [63:0] pc, input logic [31:0] ins);
        in_valid = v;
        in_pc    = pc;
        in_instr = ins;
    endtask

    initial begin
        resetn = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 64'h0, 32'h0);
        tick; tick;
        resetn = 1'b1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_misalign", 64'(out_misalign), 64'd0);

        // single pass
        out_ready = 1'b1;
        drive(1'b1, 64'h8000_0000, 32'h0000_0013);
        tick;
        drive(1'b0, 64'h0, 32'h0);
        chk("sp_out_valid", 64'(out_valid), 64'd1);
        chk("sp_pc", out_pc, 64'h8000_0000);
        chk("sp_instr", 64'(out_instr), 64'h13);
        chk("sp_misalign", 64'(out_misalign), 64'd0);
        tick;
        chk("sp_drain_valid", 64'(out_valid), 64'd0);

        // back-pressure
        out_ready = 1'b0;
        drive(1'b1, 64'h1000, 32'hA0);
        tick;
        chk("bp_count1", 64'(count), 64'd1);
        drive(1'b1, 64'h1004, 32'hA1);
        tick;
        chk("bp_count2", 64'(count), 64'd2);
        chk("bp_in_ready_full", 64'(in_ready), 64'd0);
        drive(1'b1, 64'h1008, 32'hA2);
        tick;
        chk("bp_stall_count", 64'(count), 64'd2);
        chk("bp_stall_pc", out_pc, 64'h1000);
        chk("bp_stall_instr", 64'(out_instr), 64'hA0);
        out_ready = 1'b1;
        tick;
        chk("bp_pop1_count", 64'(count), 64'd1);
        chk("bp_pop1_pc", out_pc, 64'h1004);
        chk("bp_pop1_in_ready", 64'(in_ready), 64'd1);
        tick;
        drive(1'b0, 64'h0, 32'h0);
        chk("bp_pop2_count", 64'(count), 64'd1);
        chk("bp_third_pc", out_pc, 64'h1008);
        chk("bp_third_instr", 64'(out_instr), 64'hA2);
        tick;
        chk("bp_empty", 64'(out_valid), 64'd0);

        // streaming with wrap
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 64'h2000 + 64'(4 * k), 32'(k));
            tick;
            chk("st_count", 64'(count), 64'd1);
            chk("st_pc", out_pc, 64'h2000 + 64'(4 * k));
            chk("st_instr", 64'(out_instr), 64'(k));
        end
        drive(1'b0, 64'h0, 32'h0);
        tick;
        chk("st_drain", 64'(count), 64'd0);

        // asynchronous reset mid-cycle with count=2
        out_ready = 1'b0;
        drive(1'b1, 64'h7000, 32'h70);
        tick;
        drive(1'b1, 64'h7004, 32'h71);
        tick;
        drive(1'b0, 64'h0, 32'h0);
        chk("ar_pre_count", 64'(count), 64'd2);
        #2 resetn = 1'b0;
        #1;
        chk("ar_out_valid", 64'(out_valid), 64'd0);
        chk("ar_in_ready", 64'(in_ready), 64'd1);
        chk("ar_count", 64'(count), 64'd0);
        tick;
        resetn = 1'b1;

        // flush collision
        drive(1'b1, 64'h5000, 32'h50);
        tick;
        drive(1'b1, 64'h5004, 32'h51);
        tick;
        chk("fl_pre_count", 64'(count), 64'd2);
        flush = 1'b1; out_ready = 1'b1;
        drive(1'b1, 64'h3000, 32'h30);
        tick;
        flush = 1'b0;
        drive(1'b0, 64'h0, 32'h0);
        chk("fl_count", 64'(count), 64'd0);
        chk("fl_out_valid", 64'(out_valid), 64'd0);
        chk("fl_in_ready", 64'(in_ready), 64'd1);
        tick;
        chk("fl_no_ghost", 64'(out_valid), 64'd0);
        drive(1'b1, 64'h6000, 32'h60);
        tick;
        drive(1'b0, 64'h0, 32'h0);
        chk("fl_after_pc", out_pc, 64'h6000);
        tick;

        // misalign
        out_ready = 1'b0;
        drive(1'b1, 64'h4002, 32'h40);
        tick;
        chk("ma_flag", 64'(out_misalign), 64'd1);
        chk("ma_pc", out_pc, 64'h4002);
        drive(1'b1, 64'h4004, 32'h41);
        tick;
        drive(1'b0, 64'h0, 32'h0);
        out_ready = 1'b1;
        tick;
        chk("ma_next_pc", out_pc, 64'h4004);
        chk("ma_next_flag", 64'(out_misalign), 64'd0);
        tick;
        chk("ma_drain", 64'(out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
